// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the GMII UDP transmitter.
// State encoding, header constants and payload limits.
package udp_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK_SUM,
    ST_PREAMBLE,
    ST_ETH_HEAD,
    ST_IP_HEAD,
    ST_UDP_HEAD,
    ST_TX_DATA,
    ST_PAD,
    ST_CRC,
    ST_IFG
  } tx_state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  IP_TTL        = 8'h40;

  localparam logic [15:0] PREAMBLE_LEN  = 16'd7;
  localparam logic [15:0] ETH_HEAD_LEN  = 16'd14;
  localparam logic [15:0] IP_HEAD_LEN   = 16'd20;
  localparam logic [15:0] UDP_HEAD_LEN  = 16'd8;

  localparam logic [15:0] MIN_PAYLOAD   = 16'd18;
  localparam logic [15:0] MAX_PAYLOAD   = 16'd1472;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 (reflected 0x04C11DB7).
// Register holds the running reflected CRC, not inverted.
module crc32_d8
  import udp_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        crc_en,
  input  logic        crc_clr,
  output logic [31:0] crc_data,
  output logic [31:0] crc_next
);

  // Fold one byte into the register, LSB first.
  always_comb begin
    crc_next = crc_data ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      if (crc_next[0])
        crc_next = (crc_next >> 1) ^ 32'hEDB8_8320;
      else
        crc_next = crc_next >> 1;
    end
  end

  // Running CRC register, reloaded while the transmitter idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc_data <= CRC_INIT;
    else if (crc_clr)
      crc_data <= CRC_INIT;
    else if (crc_en)
      crc_data <= crc_next;
  end

endmodule

// File: rtl/udp_tx_gmii.sv
// UDP/IPv4/Ethernet frame builder driving a GMII transmitter.
// Pulls payload with tx_req, outputs are registered one cycle.
module udp_tx_gmii
  import udp_tx_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [15:0] BOARD_PORT = 16'd1234,
  parameter logic [47:0] DES_MAC    = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [31:0] DES_IP     = {8'd192, 8'd168, 8'd1, 8'd102},
  parameter logic [15:0] DES_PORT   = 16'd1234,
  parameter logic [7:0]  IFG_CYCLES = 8'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start_en,
  input  logic [15:0] tx_byte_num,
  input  logic [7:0]  tx_data,
  output logic        tx_req,
  output logic        tx_done,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd
);

  tx_state_t   state;
  tx_state_t   state_nx;
  logic [15:0] cnt;
  logic [15:0] byte_num;
  logic [15:0] ident;
  logic [15:0] checksum;
  logic [18:0] csum_a;
  logic [18:0] csum_b;
  logic [19:0] csum_s;

  logic [15:0] total_len;
  logic [15:0] udp_len;
  logic [111:0] eth_hdr;
  logic [159:0] ip_hdr;
  logic [63:0]  udp_hdr;

  logic [7:0]  txd_d;
  logic        en_d;
  logic        req_d;
  logic        done_d;
  logic        crc_en;
  logic        crc_clr;
  logic [31:0] crc_data;
  logic [31:0] crc_next;

  assign total_len = byte_num + 16'd28;
  assign udp_len   = byte_num + 16'd8;
  assign crc_clr   = (state == ST_IDLE);

  assign eth_hdr = {DES_MAC, BOARD_MAC, ETH_TYPE_IPV4};
  assign ip_hdr  = {8'h45, 8'h00, total_len, ident,
                    16'h4000, IP_TTL, IP_PROTO_UDP,
                    checksum, BOARD_IP, DES_IP};
  assign udp_hdr = {BOARD_PORT, DES_PORT, udp_len, 16'h0000};

  crc32_d8 u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (txd_d),
    .crc_en   (crc_en),
    .crc_clr  (crc_clr),
    .crc_data (crc_data),
    .crc_next (crc_next)
  );

  // Next state, next output byte, request and CRC enable.
  always_comb begin
    state_nx = state;
    txd_d    = 8'h00;
    en_d     = 1'b0;
    req_d    = 1'b0;
    done_d   = 1'b0;
    crc_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tx_start_en)
          state_nx = ST_CHECK_SUM;
      end
      ST_CHECK_SUM: begin
        if (cnt == 16'd3)
          state_nx = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        en_d  = 1'b1;
        txd_d = (cnt == PREAMBLE_LEN) ? 8'hD5 : 8'h55;
        if (cnt == PREAMBLE_LEN)
          state_nx = ST_ETH_HEAD;
      end
      ST_ETH_HEAD: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        txd_d  = eth_hdr[8'd111 - {1'b0, cnt[3:0], 3'b000} -: 8];
        if (cnt == ETH_HEAD_LEN - 16'd1)
          state_nx = ST_IP_HEAD;
      end
      ST_IP_HEAD: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        txd_d  = ip_hdr[8'd159 - {cnt[4:0], 3'b000} -: 8];
        if (cnt == IP_HEAD_LEN - 16'd1)
          state_nx = ST_UDP_HEAD;
      end
      ST_UDP_HEAD: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        txd_d  = udp_hdr[6'd63 - {cnt[2:0], 3'b000} -: 8];
        if (cnt == UDP_HEAD_LEN - 16'd2)
          req_d = (byte_num != 16'd0);
        if (cnt == UDP_HEAD_LEN - 16'd1) begin
          req_d    = (byte_num > 16'd1);
          state_nx = (byte_num == 16'd0) ? ST_PAD : ST_TX_DATA;
        end
      end
      ST_TX_DATA: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        txd_d  = tx_data;
        req_d  = ({1'b0, cnt} + 17'd2) < {1'b0, byte_num};
        if (cnt == byte_num - 16'd1)
          state_nx = (byte_num < MIN_PAYLOAD) ? ST_PAD : ST_CRC;
      end
      ST_PAD: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        if (cnt + byte_num == MIN_PAYLOAD - 16'd1)
          state_nx = ST_CRC;
      end
      ST_CRC: begin
        en_d  = 1'b1;
        txd_d = ~crc_data[{cnt[1:0], 3'b000} +: 8];
        if (cnt == 16'd3)
          state_nx = ST_IFG;
      end
      ST_IFG: begin
        if (cnt == {8'h00, IFG_CYCLES} - 16'd1) begin
          done_d   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register and per-state byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == ST_IDLE)
        cnt <= 16'd0;
      else
        cnt <= cnt + 16'd1;
    end
  end

  // Latch clamped payload length and advance IP ident per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_num <= 16'd0;
      ident    <= 16'd0;
    end else begin
      if (state == ST_IDLE && tx_start_en)
        byte_num <= (tx_byte_num > MAX_PAYLOAD) ?
                    MAX_PAYLOAD : tx_byte_num;
      if (done_d)
        ident <= ident + 16'd1;
    end
  end

  // Four-cycle IP header checksum: two partial sums, add, fold, fold+invert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_a   <= 19'd0;
      csum_b   <= 19'd0;
      csum_s   <= 20'd0;
      checksum <= 16'd0;
    end else if (state == ST_CHECK_SUM) begin
      unique case (cnt[1:0])
        2'd0: begin
          csum_a <= 19'h04500 + {3'b0, total_len} + {3'b0, ident}
                  + 19'h04000 + {3'b0, IP_TTL, IP_PROTO_UDP};
          csum_b <= {3'b0, BOARD_IP[31:16]} + {3'b0, BOARD_IP[15:0]}
                  + {3'b0, DES_IP[31:16]} + {3'b0, DES_IP[15:0]};
        end
        2'd1: csum_s <= {1'b0, csum_a} + {1'b0, csum_b};
        2'd2: csum_s <= {4'h0, csum_s[15:0]} + {16'h0, csum_s[19:16]};
        2'd3: checksum <= ~(csum_s[15:0] + {12'h0, csum_s[19:16]});
        default: ;
      endcase
    end
  end

  // Registered GMII, request and done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      tx_req     <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      gmii_tx_en <= en_d;
      gmii_txd   <= txd_d;
      tx_req     <= req_d;
      tx_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_udp_tx_gmii.sv
// Self-checking bench for udp_tx_gmii.
// Frames are compared against a byte-level model built from the frame format.
module tb_udp_tx_gmii;

  typedef logic [7:0] byte_q_t [$];

  localparam logic [47:0] DMAC = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [47:0] SMAC = 48'h00_11_22_33_44_55;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start_en = 1'b0;
  logic [15:0] tx_byte_num = 16'd0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_req;
  logic        tx_done;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;

  int checks = 0;
  int errors = 0;

  udp_tx_gmii dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_start_en (tx_start_en),
    .tx_byte_num (tx_byte_num),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_done     (tx_done),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd)
  );

  always #4 clk = ~clk;

  // packetiser model: byte k appears the cycle after its request
  logic [7:0] payload [0:2047];
  int  rsp_idx = 0;
  bit  rsp_req_q = 1'b0;

  always @(negedge clk) begin
    if (rsp_req_q) begin
      tx_data = payload[rsp_idx];
      rsp_idx++;
    end
    rsp_req_q = tx_req && rst_n;
    if (!gmii_tx_en) rsp_idx = 0;
  end

  // output monitor
  int cyc = 0, last_high = 0, last_gap = -1;
  int run = 0, last_run = 0, req_run = 0, last_req_run = 0;
  int req_total = 0, done_total = 0, frames_total = 0;
  bit en_prev = 1'b0, req_prev = 1'b0;
  byte_q_t cap, last_frame;

  always @(negedge clk) begin
    cyc++;
    if (gmii_tx_en) begin
      if (!en_prev) begin
        cap = {};
        run = 0;
      end
      cap.push_back(gmii_txd);
      run++;
      last_high = cyc;
    end else if (en_prev) begin
      last_frame = cap;
      last_run = run;
      frames_total++;
    end
    en_prev = gmii_tx_en;
    if (tx_req) begin
      req_total++;
      req_run++;
    end else if (req_prev) begin
      last_req_run = req_run;
      req_run = 0;
    end
    req_prev = tx_req;
    if (tx_done) begin
      done_total++;
      last_gap = cyc - last_high;
    end
  end

  // reference model
  byte_q_t     exp_frame;
  logic [15:0] exp_ident = 16'd0;
  logic [15:0] exp_csum;
  int          exp_n;

  // MSB-first CRC over bit-reversed bytes (equivalent to reflected form)
  function automatic logic [31:0] crc_raw(byte_q_t q, int from);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int k = from; k < q.size(); k++)
      for (int b = 0; b < 8; b++) begin
        logic fb = c[31] ^ q[k][b];
        c = c << 1;
        if (fb) c = c ^ 32'h04C1_1DB7;
      end
    return c;
  endfunction

  function automatic logic [31:0] rev32(logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic int first_diff();
    int m = (last_frame.size() < exp_frame.size()) ?
            last_frame.size() : exp_frame.size();
    for (int i = 0; i < m; i++)
      if (last_frame[i] !== exp_frame[i]) return i;
    if (last_frame.size() != exp_frame.size()) return m;
    return -1;
  endfunction

  function automatic logic [15:0] field16(int i);
    if (last_frame.size() > i + 1) return {last_frame[i], last_frame[i+1]};
    return 16'hxxxx;
  endfunction

  task automatic push16(logic [15:0] v);
    exp_frame.push_back(v[15:8]);
    exp_frame.push_back(v[7:0]);
  endtask

  task automatic build_exp(int n);
    logic [15:0] w [10];
    int unsigned s = 0;
    logic [31:0] f;
    exp_frame = {};
    repeat (7) exp_frame.push_back(8'h55);
    exp_frame.push_back(8'hD5);
    for (int i = 0; i < 6; i++) exp_frame.push_back(DMAC[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_frame.push_back(SMAC[47-8*i -: 8]);
    push16(16'h0800);
    w = '{16'h4500, 16'(n + 28), exp_ident, 16'h4000, 16'h4011,
          16'h0000, 16'hC0A8, 16'h010A, 16'hC0A8, 16'h0166};
    foreach (w[i]) s += w[i];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    exp_csum = ~s[15:0];
    w[5] = exp_csum;
    foreach (w[i]) push16(w[i]);
    push16(16'd1234);
    push16(16'd1234);
    push16(16'(n + 8));
    push16(16'h0000);
    for (int i = 0; i < n; i++) exp_frame.push_back(payload[i]);
    for (int i = n; i < 18; i++) exp_frame.push_back(8'h00);
    f = ~rev32(crc_raw(exp_frame, 8));
    for (int i = 0; i < 4; i++) exp_frame.push_back(f[8*i +: 8]);
  endtask

  // mode 1: incrementing payload, else random; now=0 waits an edge first
  task automatic send(int req_n, bit inc, bit now);
    exp_n = (req_n > 1472) ? 1472 : req_n;
    for (int i = 0; i < exp_n; i++)
      payload[i] = inc ? 8'(i) : 8'($urandom);
    build_exp(exp_n);
    if (!now) begin
      @(posedge clk);
      #1;
    end
    tx_byte_num = 16'(req_n);
    tx_start_en = 1'b1;
    @(posedge clk);
    #1;
    tx_start_en = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (tx_done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gmii_tx_en, tx_req, tx_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: en/req/done=%b want 000",
               {gmii_tx_en, tx_req, tx_done});
    end
    checks++;
    if (gmii_txd !== 8'h00) begin
      errors++;
      $display("FAIL reset_txd: got %h want 00", gmii_txd);
    end
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (frames_total + done_total !== 0) begin
      errors++;
      $display("FAIL idle_quiet: frames+dones=%0d want 0",
               frames_total + done_total);
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t e1;
    logic [15:0] c1;
    bit ok;
    int d;
    send(18, 1'b0, 1'b0);
    e1 = exp_frame;
    c1 = exp_csum;
    wait_done(ok);
    exp_ident++;
    send(18, 1'b0, 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_done1: no tx_done");
    end
    checks++;
    if (field16(26) !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_ident1: got %h want 0000", field16(26));
    end
    checks++;
    if (field16(32) !== c1) begin
      errors++;
      $display("FAIL b2b_csum1: got %h want %h", field16(32), c1);
    end
    checks++;
    if (crc_raw(last_frame, 8) !== 32'hC704DD7B) begin
      errors++;
      $display("FAIL b2b_residue1: got %h want c704dd7b",
               crc_raw(last_frame, 8));
    end
    wait_done(ok);
    exp_ident++;
    @(negedge clk);
    #1;
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL b2b_frame2: done=%0d first diff at %0d want -1", ok, d);
    end
    checks++;
    if (field16(26) !== 16'h0001) begin
      errors++;
      $display("FAIL b2b_ident2: got %h want 0001", field16(26));
    end
    checks++;
    if (crc_raw(last_frame, 8) !== 32'hC704DD7B) begin
      errors++;
      $display("FAIL b2b_residue2: got %h want c704dd7b",
               crc_raw(last_frame, 8));
    end
    if (e1.size() == 0) $display("note: empty model frame");
  endtask

  task automatic test_long();
    bit ok;
    int d;
    send(1290, 1'b1, 1'b0);
    wait_done(ok);
    exp_ident++;
    @(negedge clk);
    #1;
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL long_frame: done=%0d first diff at %0d want -1", ok, d);
    end
    checks++;
    if (last_run != 1344) begin
      errors++;
      $display("FAIL long_en_len: got %0d want 1344", last_run);
    end
    checks++;
    if (last_req_run != 1290) begin
      errors++;
      $display("FAIL long_req_len: got %0d want 1290", last_req_run);
    end
    checks++;
    if (field16(24) !== 16'h0526 || field16(46) !== 16'h0512) begin
      errors++;
      $display("FAIL long_lens: total %h udp %h want 0526 0512",
               field16(24), field16(46));
    end
    checks++;
    if (last_gap != 12) begin
      errors++;
      $display("FAIL long_ifg: got %0d want 12", last_gap);
    end
  endtask

  task automatic test_short();
    bit ok;
    int d, nz = 0;
    int r0 = req_total;
    send(5, 1'b0, 1'b0);
    wait_done(ok);
    exp_ident++;
    @(negedge clk);
    #1;
    for (int i = 55; i < 68 && i < last_frame.size(); i++)
      if (last_frame[i] != 8'h00) nz++;
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL short_frame: done=%0d first diff at %0d want -1", ok, d);
    end
    checks++;
    if (last_run != 72 || req_total - r0 != 5) begin
      errors++;
      $display("FAIL short_len: en %0d req %0d want 72 5",
               last_run, req_total - r0);
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL short_pad: %0d nonzero pad bytes want 0", nz);
    end
  endtask

  task automatic test_random();
    bit ok;
    int d, n, r0, f0;
    for (int t = 0; t < 6; t++) begin
      n = (t == 0) ? 0 : int'($urandom_range(60, 1));
      r0 = req_total;
      f0 = frames_total;
      send(n, 1'b0, 1'b0);
      wait_done(ok);
      exp_ident++;
      @(negedge clk);
      #1;
      d = first_diff();
      checks++;
      if (!ok || d != -1 || frames_total - f0 != 1) begin
        errors++;
        $display("FAIL rand_frame n=%0d: done=%0d diff %0d frames %0d",
                 n, ok, d, frames_total - f0);
      end
      checks++;
      if (req_total - r0 != n) begin
        errors++;
        $display("FAIL rand_req n=%0d: got %0d want %0d",
                 n, req_total - r0, n);
      end
    end
  endtask

  task automatic test_mid_start();
    bit ok;
    int d;
    int f0 = frames_total, d0 = done_total;
    send(40, 1'b0, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    tx_byte_num = 16'd7;
    tx_start_en = 1'b1;
    @(posedge clk);
    #1;
    tx_start_en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    tx_byte_num = 16'd3;
    tx_start_en = 1'b1;
    @(posedge clk);
    #1;
    tx_start_en = 1'b0;
    wait_done(ok);
    exp_ident++;
    @(negedge clk);
    #1;
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL midstart_frame: done=%0d first diff %0d want -1", ok, d);
    end
    checks++;
    if (field16(24) !== 16'd68 || field16(46) !== 16'd48) begin
      errors++;
      $display("FAIL midstart_lens: total %h udp %h want 0044 0030",
               field16(24), field16(46));
    end
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (frames_total - f0 != 1 || done_total - d0 != 1) begin
      errors++;
      $display("FAIL midstart_extra: frames %0d dones %0d want 1 1",
               frames_total - f0, done_total - d0);
    end
  endtask

  task automatic test_oversize();
    bit ok;
    int d;
    send(2000, 1'b0, 1'b0);
    wait_done(ok);
    exp_ident++;
    @(negedge clk);
    #1;
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL big_frame: done=%0d first diff %0d want -1", ok, d);
    end
    checks++;
    if (field16(24) !== 16'h05DC || last_run != 1526) begin
      errors++;
      $display("FAIL big_len: total %h en %0d want 05dc 1526",
               field16(24), last_run);
    end
    checks++;
    if (last_req_run != 1472) begin
      errors++;
      $display("FAIL big_req: got %0d want 1472", last_req_run);
    end
  endtask

  task automatic test_mid_reset();
    bit ok, seen = 1'b0;
    int d, d0;
    send(100, 1'b0, 1'b0);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = tx_req;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_wait_req: tx_req never rose");
    end
    repeat (20) @(posedge clk);
    #1;
    d0 = done_total;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gmii_tx_en !== 1'b0 || tx_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: en %b req %b want 0 0", gmii_tx_en, tx_req);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ident = 16'd0;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (done_total != d0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d dones want 0", done_total - d0);
    end
    send(18, 1'b0, 1'b0);
    wait_done(ok);
    exp_ident++;
    @(negedge clk);
    #1;
    d = first_diff();
    checks++;
    if (!ok || d != -1 || field16(26) !== 16'h0000) begin
      errors++;
      $display("FAIL rst_next_frame: done=%0d diff %0d ident %h want 1 -1 0",
               ok, d, field16(26));
    end
    checks++;
    if (crc_raw(last_frame, 8) !== 32'hC704DD7B) begin
      errors++;
      $display("FAIL rst_residue: got %h want c704dd7b",
               crc_raw(last_frame, 8));
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_long();
    test_short();
    test_random();
    test_mid_start();
    test_oversize();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
